// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences each instruction over 3-5 cycles,
// stalls on the memory-ready handshake and traps unrecognised opcodes.
module multicycle_control_fsm #(
  parameter bit SUPPORT_BNE  = 1'b1,
  parameter bit SUPPORT_JALR = 1'b1,
  parameter bit SUPPORT_LUI  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;

  // State register; reset always returns to FETCH, aborting any instruction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state_o = STATE_W'(state_q);

  // Next-state and Moore output decode; enables are suppressed while rst is high.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_BRANCH: begin
            if (funct3 == F3_BEQ || (funct3 == F3_BNE && SUPPORT_BNE)) state_d = S_BRANCH;
            else                                                       state_d = S_TRAP;
          end
          OP_JAL:       state_d = S_JAL;
          OP_JALR: begin
            if (SUPPORT_JALR && funct3 == 3'b000) state_d = S_JALR1;
            else                                  state_d = S_TRAP;
          end
          OP_LUI:       state_d = SUPPORT_LUI ? S_LUI : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = (funct3 == F3_BEQ && zero) || (funct3 == F3_BNE && !zero);
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    if (rst) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Immediate format follows the opcode alone so the datapath can extend early.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:     ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IA   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] imm;
    logic       ill;
    logic       req;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
  } obs_t;

  typedef struct {
    obs_t  exp;
    bit    which;
    string name;
  } chk_t;

  logic       clk, rst, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;

  logic       m_mem_req, m_PCWrite, m_AdrSrc, m_MemWrite, m_IRWrite, m_RegWrite, m_illegal;
  logic [1:0] m_ResultSrc, m_ALUSrcA, m_ALUSrcB, m_ALUOp;
  logic [2:0] m_ImmSrc;
  logic [3:0] m_state_o;

  obs_t obs_main, obs_min;
  chk_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_sched = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .state_o(state_o)
  );

  multicycle_control_fsm #(.SUPPORT_BNE(1'b0), .SUPPORT_JALR(1'b0), .SUPPORT_LUI(1'b0)) dut_min (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .mem_req(m_mem_req), .PCWrite(m_PCWrite), .AdrSrc(m_AdrSrc), .MemWrite(m_MemWrite),
    .IRWrite(m_IRWrite), .RegWrite(m_RegWrite), .ResultSrc(m_ResultSrc), .ALUSrcA(m_ALUSrcA),
    .ALUSrcB(m_ALUSrcB), .ALUOp(m_ALUOp), .ImmSrc(m_ImmSrc), .illegal(m_illegal),
    .state_o(m_state_o)
  );

  assign obs_main = {state_o, ImmSrc, illegal, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite,
                     RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  assign obs_min  = {m_state_o, m_ImmSrc, m_illegal, m_mem_req, m_PCWrite, m_AdrSrc, m_MemWrite,
                     m_IRWrite, m_RegWrite, m_ResultSrc, m_ALUSrcA, m_ALUSrcB, m_ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written table of the per-state outputs (handshake-gated enables excluded).
  function automatic obs_t exp_moore(input logic [3:0] st);
    obs_t e;
    e = '0;
    case (st)
      4'd0:  begin e.req = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.req = 1'b1; e.adr = 1'b1; end
      4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.req = 1'b1; e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.sb = 2'b00; e.aop = 2'b10; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      4'd8:  begin e.rw = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; end
      4'd11: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd12: begin e.sa = 2'b01; e.sb = 2'b10; end
      4'd13: begin e.sa = 2'b11; e.sb = 2'b01; end
      4'd15: begin e.ill = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      SW:      return 3'b001;
      BR:      return 3'b010;
      JAL:     return 3'b011;
      LUI:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f, input logic z,
                      input logic rdy, input logic [3:0] st, input logic pcw, input logic irw,
                      input bit which, input string nm);
    chk_t c;
    rst = r; op = o; funct3 = f; zero = z; mem_ready = rdy;
    c.exp     = exp_moore(st);
    c.exp.st  = st;
    c.exp.imm = exp_imm(o);
    c.exp.pcw = pcw;
    c.exp.irw = irw;
    if (r) begin
      c.exp.req = 1'b0; c.exp.pcw = 1'b0; c.exp.mw = 1'b0; c.exp.irw = 1'b0; c.exp.rw = 1'b0;
    end
    c.which = which;
    c.name  = nm;
    sbq.push_back(c);
    n_sched++;
    @(posedge clk); #1;
  endtask

  // Reset cycle with no check (used where the prior state is not of interest).
  task automatic quiet_rst();
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // Fetch with no wait states.
  task automatic fetch(input logic [6:0] o, input logic [2:0] f, input bit which, input string nm);
    step(1'b0, o, f, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, which, nm);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      chk_t c;
      obs_t act;
      c   = sbq.pop_front();
      act = c.which ? obs_min : obs_main;
      n_vec++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                 c.name, act, act.st, c.exp, c.exp.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = LW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(1'b1, LW, 3'b010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, "reset_state");

    // lw: 2 fetch waits, 1 memread wait
    step(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, "lw_fetch_wait1");
    step(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, "lw_fetch_wait2");
    step(1'b0, LW, 3'b010, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 0, "lw_fetch_done");
    step(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 0, "lw_decode");
    step(1'b0, LW, 3'b010, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 0, "lw_memadr");
    step(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 0, "lw_memread_wait");
    step(1'b0, LW, 3'b010, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 0, "lw_memread_done");
    step(1'b0, LW, 3'b010, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 0, "lw_memwb");

    // sw then R-type, no waits
    fetch(SW, 3'b010, 0, "sw_fetch");
    step(1'b0, SW, 3'b010, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "sw_decode");
    step(1'b0, SW, 3'b010, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 0, "sw_memadr");
    step(1'b0, SW, 3'b010, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 0, "sw_memwrite");
    fetch(RT, 3'b000, 0, "r_fetch");
    step(1'b0, RT, 3'b000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 0, "r_decode");
    step(1'b0, RT, 3'b000, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 0, "r_execr");
    step(1'b0, RT, 3'b000, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 0, "r_aluwb");

    // I-ALU
    fetch(IA, 3'b000, 0, "i_fetch");
    step(1'b0, IA, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "i_decode");
    step(1'b0, IA, 3'b000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 0, "i_execi");
    step(1'b0, IA, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 0, "i_aluwb");

    // branches
    fetch(BR, 3'b000, 0, "beq_t_fetch");
    step(1'b0, BR, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "beq_t_decode");
    step(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 0, "beq_taken");
    fetch(BR, 3'b000, 0, "beq_n_fetch");
    step(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 0, "beq_n_decode");
    step(1'b0, BR, 3'b000, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 0, "beq_not_taken");
    fetch(BR, 3'b001, 0, "bne_t_fetch");
    step(1'b0, BR, 3'b001, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 0, "bne_t_decode");
    step(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 0, "bne_taken");
    fetch(BR, 3'b001, 0, "bne_n_fetch");
    step(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "bne_n_decode");
    step(1'b0, BR, 3'b001, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 0, "bne_not_taken");

    // jalr, jal, lui
    fetch(JALR, 3'b000, 0, "jalr_fetch");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "jalr_decode");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 0, "jalr1");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 0, "jalr2");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 0, "jalr_aluwb");
    fetch(JAL, 3'b000, 0, "jal_fetch");
    step(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "jal_decode");
    step(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 0, "jal_exec");
    step(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 0, "jal_aluwb");
    fetch(LUI, 3'b000, 0, "lui_fetch");
    step(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "lui_decode");
    step(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 0, "lui_exec");
    step(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 0, "lui_aluwb");

    // illegal opcode: trap held 20 cycles, released by one rst cycle
    fetch(BAD, 3'b000, 0, "bad_fetch");
    step(1'b0, BAD, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "bad_decode");
    for (int i = 0; i < 20; i++)
      step(1'b0, BAD, 3'b000, i[0], i[1], 4'd15, 1'b0, 1'b0, 0, "trap_hold");
    if (state_o !== 4'd15 || illegal !== 1'b1) begin
      n_err++;
      $display("FAIL trap_direct: state %0d illegal %b", state_o, illegal);
    end
    step(1'b1, BAD, 3'b000, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 0, "trap_rst_cycle");
    if (illegal !== 1'b0) begin
      n_err++;
      $display("FAIL trap_release_direct: illegal %b", illegal);
    end
    step(1'b0, BAD, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, "trap_after_rst");

    // branch with unsupported funct3 traps
    step(1'b0, BR, 3'b010, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 0, "badbr_fetch");
    step(1'b0, BR, 3'b010, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 0, "badbr_decode");
    step(1'b0, BR, 3'b010, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 0, "badbr_trap");
    quiet_rst();

    // rst during a MEMWRITE wait
    fetch(SW, 3'b010, 0, "swr_fetch");
    step(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 0, "swr_decode");
    step(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 0, "swr_memadr");
    step(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 0, "swr_memwrite_wait");
    rst = 1'b1;
    #1;
    if (mem_req !== 1'b0 || MemWrite !== 1'b0) begin
      n_err++;
      $display("FAIL swr_rst_direct: mem_req %b MemWrite %b", mem_req, MemWrite);
    end
    step(1'b1, SW, 3'b010, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 0, "swr_rst_cycle");
    step(1'b0, SW, 3'b010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 0, "swr_after_rst");

    // reduced-feature instance: bne, jalr and lui all trap
    quiet_rst();
    fetch(BR, 3'b001, 1, "min_bne_fetch");
    step(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1, "min_bne_decode");
    step(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1, "min_bne_trap");
    quiet_rst();
    fetch(JALR, 3'b000, 1, "min_jalr_fetch");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1, "min_jalr_decode");
    step(1'b0, JALR, 3'b000, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1, "min_jalr_trap");
    quiet_rst();
    fetch(LUI, 3'b000, 1, "min_lui_fetch");
    step(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1, "min_lui_decode");
    step(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1, "min_lui_trap");
    quiet_rst();
    fetch(BR, 3'b000, 1, "min_beq_fetch");
    step(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1, "min_beq_decode");
    step(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1, "min_beq_taken");

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations never compared", sbq.size());
    end
    if (n_vec != n_sched) begin
      n_err++;
      $display("FAIL vector count: %0d compared, %0d scheduled", n_vec, n_sched);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err != 0) $display("FAIL: %0d errors", n_err);
    else            $display("PASS");
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle RISC-V RV32I control unit: the next generation of our single-cycle main decoder. It sequences each instruction over 3–5 cycles through a state machine and stalls on a memory-ready handshake. It supports lw, sw, R-type, I-type ALU, beq/bne, jal, jalr and lui, and traps unrecognised opcodes. It sits beside the shared ALU, IR, PC and ALUOut/Data registers of the multicycle datapath; the existing ALU decoder consumes ALUOp unchanged.

## Interface
Parameters:
- SUPPORT_BNE, default 1: bne decoded; when 0, bne is illegal.
- SUPPORT_JALR, default 1: jalr decoded; when 0, jalr is illegal.
- SUPPORT_LUI, default 1: lui decoded; when 0, lui is illegal.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  store enable
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALU result
- ALUSrcA  out  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  ALU B mux: 00=rs2, 01=imm, 10=constant 4
- ALUOp  out  2  to ALU decoder: 00=add, 01=sub/compare, 10=funct-decoded
- ImmSrc  out  3  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U
- illegal  out  1  trap flag
- state_o  out  4  current state, for debug

## Operation
- All outputs are Moore-decoded from the state register, except for these three mem_ready/zero-gated terms:
  - PCWrite and IRWrite in FETCH
  - PCWrite in BRANCH
- Any output not listed for a state is 0 in that state.
- ImmSrc is decoded combinationally from op, independent of state:
  - I-type for lw, I-ALU and jalr
  - S for sw, B for branch, J for jal, U for lui
  - 000 for any other op
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR1=11, JALR2=12, LUI=13, TRAP=15.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Transition: to DECODE if mem_ready, else stay.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - 0000011 (lw) and 0100011 (sw) go to MEMADR.
  - 0110011 (R-type) goes to EXECR; 0010011 (I-ALU) goes to EXECI.
  - 1100011 goes to BRANCH if funct3=000, or if funct3=001 and SUPPORT_BNE. Any other funct3 goes to TRAP.
  - 1101111 (jal) goes to JAL.
  - 1100111 goes to JALR1 if SUPPORT_JALR and funct3=000, else TRAP.
  - 0110111 goes to LUI if SUPPORT_LUI, else TRAP.
  - Any other op goes to TRAP.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - lw goes to MEMREAD; sw goes to MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Go to MEMWB when mem_ready, else stay.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, AdrSrc=1, MemWrite=1.
  - MemWrite stays held for every wait cycle.
  - Go to FETCH when mem_ready, else stay.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Go to FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Go to ALUWB, which writes OldPC+4 to rd.
- JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (target into ALUOut). Go to JALR2.
- JALR2: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Go to ALUWB.
- TRAP: illegal=1. All enables stay 0. Held until rst.

## Timing
- Reset:
  - rst sampled high at a rising edge sets state to FETCH.
  - While rst is high, PCWrite, IRWrite, MemWrite, RegWrite and mem_req are forced to 0, overriding the state decode.
  - Reset asserted mid-instruction (any state, including memory wait states) aborts the instruction and leaves no partial write. Next state is FETCH; illegal reads 0 from the cycle after reset.
- Latency with zero wait states (mem_ready=1):
  - beq/bne: 3 cycles.
  - R-type, I-ALU, jal, lui: 4 cycles.
  - sw: 4 cycles.
  - jalr, lw: 5 cycles.
  - Each wait cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- Handshake:
  - mem_req rises on entry to FETCH, MEMREAD and MEMWRITE, and stays high until the cycle mem_ready=1.
  - mem_ready is ignored in every other state.
  - PC and IR update exactly once per fetch, regardless of wait count.
- zero is sampled only in BRANCH, in the same cycle.

## Test plan
- lw with mem_ready low for 2 cycles in FETCH and 1 in MEMREAD:
  - Required: state path 0,0,0,1,2,3,3,4,0 over 9 cycles.
  - PCWrite and IRWrite high exactly once; RegWrite high only in MEMWB, with ResultSrc=01.
- sw then R-type (0110011), no waits:
  - Required: MemWrite high for 1 cycle with AdrSrc=1.
  - R-type path 0,1,6,8, with ALUOp=10 in EXECR.
- beq (funct3=000) with zero=1, then with zero=0:
  - Required: PCWrite=1 in BRANCH for the first, 0 for the second.
  - bne (funct3=001) with zero=0 gives PCWrite=1.
  - With SUPPORT_BNE=0, the same bne gives illegal=1 and state 15.
- jalr (1100111):
  - Required: path 0,1,11,12,8.
  - JALR2 drives ALUSrcA=01, ALUSrcB=10, PCWrite=1.
  - ALUWB drives RegWrite=1 with ResultSrc=00.
- op=1111111:
  - Required: state 15 and illegal=1 for 20 cycles, all enables 0.
  - After one rst cycle: state 0, illegal=0.
- rst pulsed during MEMWRITE wait, with mem_ready=0:
  - Required: MemWrite and mem_req are 0 in the reset cycle.
  - The next cycle is FETCH with mem_req=1 and no RegWrite pulse.
